// File: rtl/bram_compute_pkg.sv
// Shared definitions for the BRAM compute engine: op-mode codes and FSM states.
package bram_compute_pkg;

    localparam logic [1:0] OP_PASS = 2'd0;
    localparam logic [1:0] OP_SHL  = 2'd1;
    localparam logic [1:0] OP_ADD  = 2'd2;
    localparam logic [1:0] OP_SAT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/bram_tdp.sv
// Inferred true-dual-port RAM, read-first, both ports on one clock.
module bram_tdp #(
    parameter int DATA = 18,
    parameter int ADDR = 9
) (
    input  logic            clk,
    input  logic            a_we,
    input  logic [ADDR-1:0] a_addr,
    input  logic [DATA-1:0] a_din,
    output logic [DATA-1:0] a_dout,
    input  logic            b_we,
    input  logic [ADDR-1:0] b_addr,
    input  logic [DATA-1:0] b_din,
    output logic [DATA-1:0] b_dout
);

    logic [DATA-1:0] mem [0:(1<<ADDR)-1];

    // Both ports write and register their read data on the same edge (old data on collision).
    always_ff @(posedge clk) begin
        if (a_we) begin
            mem[a_addr] <= a_din;
        end
        if (b_we) begin
            mem[b_addr] <= b_din;
        end
        a_dout <= mem[a_addr];
        b_dout <= mem[b_addr];
    end

endmodule

// File: rtl/bram_compute_engine.sv
// Sweeps a (base, length) window of an owned BRAM applying one arithmetic op per word.
// Port B streams reads, port A writes results back one cycle later or serves the host.
module bram_compute_engine
    import bram_compute_pkg::*;
#(
    parameter int DATA = 18,
    parameter int ADDR = 9,
    parameter int SHW  = 4
) (
    input  logic            clk1,
    input  logic            reset,
    input  logic            host_wr,
    input  logic            host_rd,
    input  logic [ADDR-1:0] host_addr,
    input  logic [DATA-1:0] host_din,
    output logic [DATA-1:0] host_dout,
    output logic            host_dout_valid,
    output logic            host_err,
    input  logic            start,
    input  logic [ADDR-1:0] base_addr,
    input  logic [ADDR:0]   length,
    input  logic [1:0]      op_mode,
    input  logic [DATA-1:0] op_arg,
    output logic            busy,
    output logic            done
);

    localparam logic [ADDR:0] DEPTH_W = {1'b1, {ADDR{1'b0}}};

    state_t          state;
    state_t          state_next;
    logic [ADDR-1:0] base_q;
    logic [ADDR:0]   len_q;
    logic [ADDR:0]   cnt;
    logic [1:0]      mode_q;
    logic [DATA-1:0] arg_q;
    logic            wr_valid;
    logic [ADDR-1:0] wr_addr;
    logic [ADDR-1:0] rd_addr;
    logic            a_we;
    logic [ADDR-1:0] a_addr;
    logic [DATA-1:0] a_din;
    logic [DATA-1:0] a_dout;
    logic [DATA-1:0] b_dout;
    logic [DATA-1:0] op_result;
    logic [DATA-1:0] host_hold;

    function automatic logic [DATA-1:0] apply_op(input logic [1:0]      mode,
                                                 input logic [DATA-1:0] x,
                                                 input logic [DATA-1:0] arg);
        logic [DATA:0] sum;
        sum = {1'b0, x} + {1'b0, arg};
        case (mode)
            OP_PASS: apply_op = x;
            OP_SHL:  apply_op = x << arg[SHW-1:0];
            OP_ADD:  apply_op = sum[DATA-1:0];
            OP_SAT:  apply_op = sum[DATA] ? {DATA{1'b1}} : sum[DATA-1:0];
            default: apply_op = x;
        endcase
    endfunction

    bram_tdp #(
        .DATA(DATA),
        .ADDR(ADDR)
    ) u_ram (
        .clk    (clk1),
        .a_we   (a_we),
        .a_addr (a_addr),
        .a_din  (a_din),
        .a_dout (a_dout),
        .b_we   (1'b0),
        .b_addr (rd_addr),
        .b_din  ({DATA{1'b0}}),
        .b_dout (b_dout)
    );

    assign op_result = apply_op(mode_q, b_dout, arg_q);
    assign host_dout = host_dout_valid ? a_dout : host_hold;

    // State register.
    always_ff @(posedge clk1) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a zero-length start skips the sweep entirely.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = (length == '0) ? ST_DONE : ST_RUN;
            ST_RUN:   if (cnt == len_q - 1'b1) state_next = ST_DRAIN;
            ST_DRAIN: state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Status outputs and the current sweep read address (wraps modulo depth).
    always_comb begin
        busy    = (state == ST_RUN) || (state == ST_DRAIN);
        done    = (state == ST_DONE);
        rd_addr = base_q + cnt[ADDR-1:0];
    end

    // Job latch, read counter and the one-deep write-back address pipeline.
    always_ff @(posedge clk1) begin
        if (reset) begin
            base_q   <= '0;
            len_q    <= '0;
            mode_q   <= OP_PASS;
            arg_q    <= '0;
            cnt      <= '0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
        end else begin
            wr_valid <= (state == ST_RUN);
            wr_addr  <= rd_addr;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        base_q <= base_addr;
                        len_q  <= (length > DEPTH_W) ? DEPTH_W : length;
                        mode_q <= op_mode;
                        arg_q  <= op_arg;
                        cnt    <= '0;
                    end
                end
                ST_RUN:  cnt <= cnt + 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Port A goes to the engine write-back when one is pending, else to the host.
    always_comb begin
        a_we   = 1'b0;
        a_addr = host_addr;
        a_din  = host_din;
        if (wr_valid) begin
            a_we   = 1'b1;
            a_addr = wr_addr;
            a_din  = op_result;
        end else if (!busy && host_wr) begin
            a_we = 1'b1;
        end
    end

    // Host response flags and the held copy of the last returned read word.
    always_ff @(posedge clk1) begin
        if (reset) begin
            host_dout_valid <= 1'b0;
            host_err        <= 1'b0;
            host_hold       <= '0;
        end else begin
            host_dout_valid <= !busy && host_rd && !host_wr;
            host_err        <= busy && (host_wr || host_rd);
            if (host_dout_valid) begin
                host_hold <= a_dout;
            end
        end
    end

endmodule

// File: tb/tb_bram_compute_engine.sv
// Self-checking bench for bram_compute_engine against an array-based memory model.
module tb_bram_compute_engine;

    localparam int DATA  = 18;
    localparam int ADDR  = 9;
    localparam int DEPTH = 512;
    localparam int MAXV  = (1 << DATA) - 1;

    logic            clk1 = 1'b0;
    logic            reset;
    logic            host_wr;
    logic            host_rd;
    logic [ADDR-1:0] host_addr;
    logic [DATA-1:0] host_din;
    logic [DATA-1:0] host_dout;
    logic            host_dout_valid;
    logic            host_err;
    logic            start;
    logic [ADDR-1:0] base_addr;
    logic [ADDR:0]   length;
    logic [1:0]      op_mode;
    logic [DATA-1:0] op_arg;
    logic            busy;
    logic            done;

    int              vectors     = 0;
    int              miscompares = 0;
    logic [DATA-1:0] model_mem [DEPTH];
    logic [DATA-1:0] last_read;

    always #5 clk1 = ~clk1;

    bram_compute_engine dut (
        .clk1            (clk1),
        .reset           (reset),
        .host_wr         (host_wr),
        .host_rd         (host_rd),
        .host_addr       (host_addr),
        .host_din        (host_din),
        .host_dout       (host_dout),
        .host_dout_valid (host_dout_valid),
        .host_err        (host_err),
        .start           (start),
        .base_addr       (base_addr),
        .length          (length),
        .op_mode         (op_mode),
        .op_arg          (op_arg),
        .busy            (busy),
        .done            (done)
    );

    // Reference op straight from the arithmetic definitions.
    function automatic logic [DATA-1:0] refOp(input int mode, input logic [DATA-1:0] x,
                                              input logic [DATA-1:0] arg);
        longint xv = longint'(x);
        longint av = longint'(arg);
        longint r;
        case (mode)
            0:       r = xv;
            1:       r = (xv * (longint'(1) << arg[3:0])) % (longint'(MAXV) + 1);
            2:       r = (xv + av) % (longint'(MAXV) + 1);
            default: r = (xv + av > longint'(MAXV)) ? longint'(MAXV) : xv + av;
        endcase
        return DATA'(r);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic hostWrite(input int a, input logic [DATA-1:0] d);
        host_wr   = 1'b1;
        host_addr = ADDR'(a);
        host_din  = d;
        tick();
        host_wr      = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic hostRead(input int a, input string tag);
        host_rd   = 1'b1;
        host_addr = ADDR'(a);
        tick();
        host_rd = 1'b0;
        checkOutput({tag, "_valid"}, 64'(host_dout_valid), 64'(1));
        checkOutput(tag, 64'(host_dout), 64'(model_mem[a]));
        last_read = model_mem[a];
    endtask

    task automatic checkWindow(input int b, input int len, input string tag);
        for (int i = -1; i <= len; i++) begin
            int a = (b + i + DEPTH) % DEPTH;
            hostRead(a, $sformatf("%s[%0d]", tag, a));
        end
    endtask

    task automatic applyStimulus(input int b, input int len, input int mode,
                                 input logic [DATA-1:0] arg);
        base_addr = ADDR'(b);
        length    = (ADDR+1)'(len);
        op_mode   = 2'(mode);
        op_arg    = arg;
        start     = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic applyModel(input int b, input int len, input int mode,
                              input logic [DATA-1:0] arg);
        int eff = (len > DEPTH) ? DEPTH : len;
        for (int i = 0; i < eff; i++) begin
            int a = (b + i) % DEPTH;
            model_mem[a] = refOp(mode, model_mem[a], arg);
        end
    endtask

    task automatic runSweep(input int b, input int len, input int mode,
                            input logic [DATA-1:0] arg, input string tag);
        int n   = 0;
        int eff = (len > DEPTH) ? DEPTH : len;
        int exp_n = (eff == 0) ? 0 : eff + 1;
        applyStimulus(b, len, mode, arg);
        checkOutput({tag, "_busy"}, 64'(busy), 64'(eff != 0));
        while (!done && n < 4 * DEPTH) begin
            tick();
            n++;
        end
        checkOutput({tag, "_latency"}, 64'(n), 64'(exp_n));
        checkOutput({tag, "_busy_at_done"}, 64'(busy), 64'(0));
        applyModel(b, len, mode, arg);
        tick();
        checkOutput({tag, "_done_pulse"}, 64'(done), 64'(0));
    endtask

    initial begin
        int pulses;
        int b;
        int len;
        int mode;
        logic [DATA-1:0] arg;
        logic [DATA-1:0] d;

        reset = 1'b1; host_wr = 1'b0; host_rd = 1'b0; host_addr = '0; host_din = '0;
        start = 1'b0; base_addr = '0; length = '0; op_mode = '0; op_arg = '0;
        last_read = '0;
        repeat (3) tick();
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_done", 64'(done), 64'(0));
        checkOutput("rst_err", 64'(host_err), 64'(0));
        checkOutput("rst_valid", 64'(host_dout_valid), 64'(0));
        checkOutput("rst_dout", 64'(host_dout), 64'(0));
        reset = 1'b0;
        tick();

        $display("[TB] preload");
        for (int a = 0; a < DEPTH; a++) begin
            hostWrite(a, (a < 8) ? DATA'(a + 1) : DATA'($urandom));
        end

        $display("[TB] shift-left sweep of words 0..7");
        runSweep(0, 8, 1, 1, "shl8");
        checkWindow(0, 10, "shl8");

        $display("[TB] saturate and wrap on one word");
        hostWrite(3, 18'h3FFF0);
        runSweep(3, 1, 3, 18'h20, "sat1");
        hostRead(3, "sat1_w3");
        hostWrite(3, 18'h3FFF0);
        runSweep(3, 1, 2, 18'h20, "add1");
        hostRead(3, "add1_w3");

        $display("[TB] address wrap-around");
        for (int a = DEPTH - 3; a < DEPTH + 3; a++) hostWrite(a % DEPTH, '0);
        runSweep(DEPTH - 2, 4, 2, 5, "wrap");
        checkWindow(DEPTH - 2, 4, "wrap");

        $display("[TB] zero length");
        runSweep(20, 0, 2, 7, "len0");
        checkWindow(20, 0, "len0");

        $display("[TB] simultaneous host write and read");
        d = DATA'($urandom);
        host_wr = 1'b1; host_rd = 1'b1; host_addr = ADDR'(40); host_din = d;
        tick();
        host_wr = 1'b0; host_rd = 1'b0;
        model_mem[40] = d;
        checkOutput("wr_rd_valid", 64'(host_dout_valid), 64'(0));
        checkOutput("wr_rd_err", 64'(host_err), 64'(0));
        hostRead(40, "wr_rd_w40");

        $display("[TB] full-depth sweep and clamped length");
        runSweep($urandom_range(0, DEPTH - 1), DEPTH, $urandom_range(1, 3),
                 DATA'($urandom), "full");
        for (int a = 0; a < DEPTH; a++) hostRead(a, $sformatf("full[%0d]", a));
        runSweep(5, 1023, 0, 0, "clamp");

        $display("[TB] host access and restart while busy");
        hostRead(200, "pre_busy");
        arg = DATA'($urandom);
        applyStimulus(0, 16, 2, arg);
        tick();
        tick();
        host_wr = 1'b1; host_addr = ADDR'(7); host_din = ~model_mem[7];
        tick();
        host_wr = 1'b0;
        checkOutput("busy_wr_err", 64'(host_err), 64'(1));
        checkOutput("busy_wr_valid", 64'(host_dout_valid), 64'(0));
        host_rd = 1'b1; host_addr = ADDR'(7);
        base_addr = ADDR'(300); length = (ADDR+1)'(5); op_mode = 2'd2; op_arg = 18'h1;
        start = 1'b1;
        tick();
        host_rd = 1'b0; start = 1'b0;
        checkOutput("busy_rd_err", 64'(host_err), 64'(1));
        checkOutput("busy_rd_valid", 64'(host_dout_valid), 64'(0));
        checkOutput("busy_rd_hold", 64'(host_dout), 64'(last_read));
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) pulses++;
            tick();
        end
        checkOutput("busy_done_pulses", 64'(pulses), 64'(1));
        checkOutput("busy_idle", 64'(busy), 64'(0));
        applyModel(0, 16, 2, arg);
        hostRead(7, "busy_w7");
        checkWindow(0, 16, "busy");
        checkWindow(300, 5, "ignored");

        $display("[TB] reset mid-sweep");
        arg = DATA'($urandom_range(1, 15));
        applyStimulus(100, 16, 1, arg);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("abort_busy", 64'(busy), 64'(0));
        checkOutput("abort_done", 64'(done), 64'(0));
        applyModel(100, 2, 1, arg);
        tick();
        checkOutput("abort_no_done", 64'(done), 64'(0));
        checkWindow(100, 16, "abort");
        runSweep(100, 16, 2, 18'h3, "after_abort");
        checkWindow(100, 16, "after_abort");

        $display("[TB] random sweeps");
        for (int k = 0; k < 8; k++) begin
            b    = $urandom_range(0, DEPTH - 1);
            len  = $urandom_range(0, 24);
            mode = $urandom_range(0, 3);
            arg  = DATA'($urandom);
            runSweep(b, len, mode, arg, $sformatf("rnd%0d", k));
            checkWindow(b, len, $sformatf("rnd%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
